// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer between the core memory stage and a byte-addressed, big-lane data memory.
// Sub-word stores are done as read-modify-write; misaligned, illegal or out-of-range requests get err.
module dmem_lsu_ctrl #(
    parameter int ADDR_BITS = 21
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    // Handshakes: a request transfers on a rising edge with req_valid && req_ready;
    // a response transfers on a rising edge with resp_valid && resp_ready.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   lat_we;
    logic [2:0]             lat_f3;
    logic [ADDR_BITS-1:0]   lat_addr;
    logic [31:0]            lat_wdata;
    logic [31:0]            old_word;
    logic [31:0]            rdata_q;
    logic                   err_q;
    logic [31:0]            store_word;
    logic                   req_fire;
    logic                   req_err;
    logic                   req_misalign;
    logic                   req_bad_f3;
    logic                   req_oor;

    // Memory lane 31:24 holds the byte at the addressed location.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [31:0] m);
        case (f3)
            3'd0:    return {{24{m[31]}}, m[31:24]};
            3'd1:    return {{16{m[23]}}, m[23:16], m[31:24]};
            3'd2:    return {m[7:0], m[15:8], m[23:16], m[31:24]};
            3'd4:    return {24'd0, m[31:24]};
            3'd5:    return {16'd0, m[23:16], m[31:24]};
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        req_oor    = |req_addr[31:ADDR_BITS];
        req_bad_f3 = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7)
                     || (req_we && (req_funct3 > 3'd2));
        case (req_funct3[1:0])
            2'd1:    req_misalign = req_addr[0];
            2'd2:    req_misalign = |req_addr[1:0];
            default: req_misalign = 1'b0;
        endcase
        req_err  = req_oor || req_bad_f3 || req_misalign;
        req_fire = (state == IDLE) && req_valid;
    end

    always_comb begin
        case (lat_f3[1:0])
            2'd0:    store_word = {lat_wdata[7:0], old_word[23:0]};
            2'd1:    store_word = {lat_wdata[7:0], lat_wdata[15:8], old_word[15:0]};
            default: store_word = {lat_wdata[7:0], lat_wdata[15:8], lat_wdata[23:16], lat_wdata[31:24]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)                      state_next = RESP;
                    else if (req_we && req_funct3 == 3'd2) state_next = WR;
                    else                              state_next = RD;
                end
            end
            RD:      state_next = lat_we ? WR : RESP;
            WR:      state_next = RESP;
            RESP:    state_next = resp_ready ? IDLE : RESP;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_we    <= 1'b0;
            lat_f3    <= 3'd0;
            lat_addr  <= '0;
            lat_wdata <= 32'd0;
            old_word  <= 32'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            if (req_fire) begin
                lat_we    <= req_we;
                lat_f3    <= req_funct3;
                lat_addr  <= req_addr[ADDR_BITS-1:0];
                lat_wdata <= req_wdata;
                err_q     <= req_err;
                rdata_q   <= 32'd0;
            end
            if (state == RD) begin
                old_word <= mem_rdata;
                if (!lat_we) rdata_q <= load_extract(lat_f3, mem_rdata);
            end
        end
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        mem_we     = (state == WR);
        mem_addr   = {{(32-ADDR_BITS){1'b0}}, lat_addr};
        mem_wdata  = store_word;
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Bench for dmem_lsu_ctrl: byte-array memory, byte-level reference model, per-cycle response monitor.
module tb_dmem_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    dmem_lsu_ctrl #(.ADDR_BITS(21)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Data memory: 4 KiB window, byte at mem_addr on lane 31:24.
    logic [7:0] mem [0:4095];
    logic [11:0] ma;
    assign ma = mem_addr[11:0];
    assign mem_rdata = {mem[ma], mem[ma + 12'd1], mem[ma + 12'd2], mem[ma + 12'd3]};

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i);
        forever begin
            @(posedge clk);
            if (mem_we) begin
                mem[ma]         <= mem_wdata[31:24];
                mem[ma + 12'd1] <= mem_wdata[23:16];
                mem[ma + 12'd2] <= mem_wdata[15:8];
                mem[ma + 12'd3] <= mem_wdata[7:0];
            end
        end
    end

    // Scoreboard
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t       exp_q[$];
    logic [63:0] wr_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  ref_mem [0:4095];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Reference model: RISC-V semantics over a little-endian byte array.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] w, output logic [31:0] rd, output logic err,
                         output logic wr, output logic [31:0] wd, output int lat);
        int size;
        logic [31:0] le;
        logic [11:0] b;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        err = (f3 == 3'd3) || (f3 >= 3'd6) || (we && f3 > 3'd2) || ((a >> 21) != 0)
              || ((a % size) != 0);
        rd = 32'd0; wr = 1'b0; wd = 32'd0;
        b = a[11:0];
        if (err) begin
            lat = 1;
        end else if (!we) begin
            lat = 2;
            le = {ref_mem[b + 12'd3], ref_mem[b + 12'd2], ref_mem[b + 12'd1], ref_mem[b]};
            if (size == 1)      rd = f3[2] ? {24'd0, le[7:0]} : {{24{le[7]}}, le[7:0]};
            else if (size == 2) rd = f3[2] ? {16'd0, le[15:0]} : {{16{le[15]}}, le[15:0]};
            else                rd = le;
        end else begin
            lat = (size == 4) ? 2 : 3;
            for (int k = 0; k < size; k++) ref_mem[b + 12'(k)] = w[8*k +: 8];
            wr = 1'b1;
            wd = {ref_mem[b], ref_mem[b + 12'd1], ref_mem[b + 12'd2], ref_mem[b + 12'd3]};
        end
    endtask

    // Compare process: every response cycle and every memory write cycle.
    resp_t cur = '0;
    logic  was_valid = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            was_valid = 1'b0;
        end else begin
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL mem_we: got unexpected write at %h expected none", mem_addr);
                end else begin
                    logic [63:0] e;
                    e = wr_q.pop_front();
                    check("mem_addr", mem_addr, e[63:32]);
                    check("mem_wdata", mem_wdata, e[31:0]);
                end
            end
            if (resp_valid) begin
                if (!was_valid) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL resp_valid: got unexpected response expected none");
                        cur = '0;
                    end else begin
                        cur = exp_q.pop_front();
                    end
                end
                check("resp_rdata", resp_rdata, cur.rdata);
                check("resp_err", {31'd0, resp_err}, {31'd0, cur.err});
                check("req_ready_busy", {31'd0, req_ready}, 32'd0);
            end
            was_valid = resp_valid;
        end
    end

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] w, input int stall,
                          output logic [31:0] mrd, output logic [31:0] mwd);
        logic err, wr;
        int lat, n;
        model(we, f3, a, w, mrd, err, wr, mwd, lat);
        exp_q.push_back('{rdata: mrd, err: err});
        if (wr) wr_q.push_back({a, mwd});
        step();
        n = 0;
        while (!req_ready && n < 20) begin step(); n++; end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = w;
        @(posedge clk);
        lat = 1;
        step();
        req_valid = 1'b0;
        req_we = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        while (!resp_valid && lat < 10) begin
            resp_ready = 1'($urandom);
            @(posedge clk);
            lat++;
            step();
        end
        resp_ready = 1'b0;
        check("latency", 32'(lat), 32'(lat == 10 && !resp_valid ? -1 : 0) + 32'(lat));
        check("latency_spec", 32'(resp_valid ? lat : 99), 32'(lat_expected(we, f3, a)));
        repeat (stall) step();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("idle_after_resp", {31'd0, req_ready}, 32'd1);
        check("resp_dropped", {31'd0, resp_valid}, 32'd0);
    endtask

    function automatic int lat_expected(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int size;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if ((f3 == 3'd3) || (f3 >= 3'd6) || (we && f3 > 3'd2) || ((a >> 21) != 0) || ((a % size) != 0))
            return 1;
        if (!we || size == 4) return 2;
        return 3;
    endfunction

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd, wd, wd_rst;
        logic        e, wr;
        int          lat;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'(i);

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        step();
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;

        do_req(1'b0, 3'd2, 32'h100, 32'd0, 0, rd, wd); check("pin_lw", rd, 32'h03020100);
        do_req(1'b0, 3'd0, 32'h183, 32'd0, 1, rd, wd); check("pin_lb", rd, 32'hFFFFFF83);
        do_req(1'b0, 3'd4, 32'h183, 32'd0, 0, rd, wd); check("pin_lbu", rd, 32'h00000083);
        do_req(1'b0, 3'd1, 32'h1FE, 32'd0, 0, rd, wd); check("pin_lh", rd, 32'hFFFFFFFE);
        do_req(1'b0, 3'd5, 32'h1FE, 32'd0, 2, rd, wd); check("pin_lhu", rd, 32'h0000FFFE);
        do_req(1'b1, 3'd0, 32'h201, 32'hAA, 0, rd, wd); check("pin_sb_word", wd, 32'hAA020304);
        do_req(1'b0, 3'd2, 32'h200, 32'd0, 0, rd, wd); check("pin_lw_after_sb", rd, 32'h0302AA00);
        do_req(1'b1, 3'd2, 32'h300, 32'hDEADBEEF, 0, rd, wd); check("pin_sw_word", wd, 32'hEFBEADDE);
        do_req(1'b0, 3'd2, 32'h300, 32'd0, 0, rd, wd); check("pin_lw_after_sw", rd, 32'hDEADBEEF);
        do_req(1'b1, 3'd1, 32'h502, 32'h1234, 0, rd, wd); check("pin_sh_word", wd, 32'h34120405);
        do_req(1'b0, 3'd2, 32'h102, 32'd0, 0, rd, wd);
        do_req(1'b1, 3'd1, 32'h001, 32'h5555, 0, rd, wd);
        do_req(1'b0, 3'd3, 32'h100, 32'd0, 0, rd, wd);
        do_req(1'b0, 3'd2, 32'h00200000, 32'd0, 1, rd, wd); check("pin_oor_rdata", rd, 32'd0);
        do_req(1'b0, 3'd2, 32'h104, 32'd0, 3, rd, wd); check("pin_lw_stall", rd, 32'h07060504);

        // Reset while the sub-word store is in its write cycle: write lands, response is dropped.
        model(1'b1, 3'd0, 32'h400, 32'h55, rd, e, wr, wd_rst, lat);
        check("pin_sb_rst_word", wd_rst, 32'h55010203);
        wr_q.push_back({32'h400, wd_rst});
        step();
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h400; req_wdata = 32'h55;
        @(posedge clk);
        step();
        req_valid = 1'b0;
        @(posedge clk);
        step();
        check("wr_state_we", {31'd0, mem_we}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        step();
        check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        check("midrst_mem_we", {31'd0, mem_we}, 32'd0);
        check("midrst_mem_addr", mem_addr, 32'd0);
        rst_n = 1'b1;
        do_req(1'b0, 3'd2, 32'h400, 32'd0, 0, rd, wd); check("pin_lw_after_rst", rd, 32'h03020155);

        for (int t = 0; t < 150; t++) begin
            logic [31:0] a;
            a = $urandom_range(0, 32'hFF0);
            if ($urandom_range(0, 15) == 0) a[$urandom_range(21, 31)] = 1'b1;
            do_req(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, $urandom_range(0, 2), rd, wd);
        end

        step();
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);
        for (int i = 0; i < 4096; i += 256) begin
            check("mem_image", {mem[i], mem[i+1], mem[i+2], mem[i+3]},
                  {ref_mem[i], ref_mem[i+1], ref_mem[i+2], ref_mem[i+3]});
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
